uart_tx_frame: RTL and testbench

Parametrised UART transmitter with an input FIFO, configurable data width, parity and stop-bit count. It accepts bytes on a valid/ready handshake, buffers them, and serialises complete frames (start, data LSB-first, optional parity, stop) onto `tx_serial`. Bit timing comes from an external one-cycle `baud_tick` strobe, so the block sits between the shared baud generator and the pad, replacing the fixed 8N1 transmitter.

---
 rtl/uart_tx_frame.sv | 154 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// uart_tx_frame: FIFO-buffered UART transmitter with configurable data width,
// parity and stop-bit count; bit timing comes from an external baud_tick strobe.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        baud_tick,
  input  logic                        tx_valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_ready,
  output logic                        tx_serial,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 push, pop;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 serial_n, done_n;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (^w) ^ (PARITY == 2);
  endfunction

  // Input FIFO: ready comes from the registered count, so a full FIFO refuses
  // a push even on the cycle a pop frees an entry.
  assign tx_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push     = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame sequencer: every transition and line change happens on baud_tick
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    serial_n   = tx_serial;
    done_n     = 1'b0;
    pop        = 1'b0;
    if (baud_tick) begin
      unique case (state)
        S_IDLE: pop = (fifo_count != '0);
        S_START: begin
          serial_n = shreg[0];
          shreg_n  = shreg >> 1;
          state_n  = S_DATA;
        end
        S_DATA: begin
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_n  = S_PARITY;
              serial_n = par_bit;
            end else begin
              state_n    = S_STOP;
              serial_n   = 1'b1;
              stop_cnt_n = 1'b0;
            end
          end else begin
            serial_n  = shreg[0];
            shreg_n   = shreg >> 1;
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
        S_PARITY: begin
          state_n    = S_STOP;
          serial_n   = 1'b1;
          stop_cnt_n = 1'b0;
        end
        S_STOP: begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            done_n = 1'b1;
            pop    = (fifo_count != '0);
            if (!pop) begin
              state_n  = S_IDLE;
              serial_n = 1'b1;
            end
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
      // A pop always starts a frame, whether from IDLE or back-to-back from STOP
      if (pop) begin
        state_n   = S_START;
        serial_n  = 1'b0;
        bit_cnt_n = '0;
        shreg_n   = mem[rd_ptr];
        par_bit_n = parity_of(mem[rd_ptr]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      stop_cnt  <= stop_cnt_n;
      tx_serial <= serial_n;
      tx_done   <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg   <= shreg_n;
    par_bit <= par_bit_n;
  end

  assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
// Bench for uart_tx_frame: three configurations (8N1, 7O2, 8E1) share clock,
// reset and baud_tick; a per-instance bit queue predicts the serial line.
module tb_uart_tx_frame;

  localparam int ND    = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud_tick = 1'b0;
  logic [ND-1:0]      v = '0;
  logic [ND-1:0][8:0] dat = '0;
  logic [ND-1:0]      ser, busy, done, rdy;
  logic [ND-1:0][2:0] fc;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(v[0]), .tx_data(dat[0][7:0]),
    .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]),
    .fifo_count(fc[0]));

  uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7o2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(v[1]), .tx_data(dat[1][6:0]),
    .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]),
    .fifo_count(fc[1]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_valid(v[2]), .tx_data(dat[2][7:0]),
    .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]),
    .fifo_count(fc[2]));

  // entry: {last stop bit, start bit, line value}
  typedef logic [2:0] ent_t;
  ent_t q0[$], q1[$], q2[$];

  typedef struct {
    int          d;
    logic [8:0]  w;
    logic [15:0] fr;
    int          n;
  } vec_t;
  vec_t tbl [5];

  int n_checks = 0;
  int n_fail   = 0;
  int cnt      [ND] = '{default: 0};
  int gap      [ND] = '{default: 0};
  int last_done[ND] = '{default: 0};
  int done_cnt [ND] = '{default: 0};
  logic [ND-1:0] pend = '0;
  int tick_no = 0;
  int dc_snap;

  always @(posedge clk)
    for (int d = 0; d < ND; d++)
      if (done[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  function automatic int sb_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t sb_pop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic sb_push(input int d, input ent_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Reference frame builder: line bits in time order, first bit at MSB of n
  task automatic frame_model(input int d, input logic [8:0] w, output logic [15:0] f, output int n);
    int nb, par, sb;
    logic p;
    case (d)
      0:       begin nb = 8; par = 0; sb = 1; end
      1:       begin nb = 7; par = 2; sb = 2; end
      default: begin nb = 8; par = 1; sb = 1; end
    endcase
    f = 16'h0; n = 1; p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f = {f[14:0], w[i]}; p ^= w[i]; n++;
    end
    if (par != 0) begin
      f = {f[14:0], p ^ (par == 2)}; n++;
    end
    for (int i = 0; i < sb; i++) begin
      f = {f[14:0], 1'b1}; n++;
    end
  endtask

  task automatic sb_frame(input int d, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++)
      sb_push(d, {(i == n - 1), (i == 0), f[n-1-i]});
  endtask

  task automatic push(input int d, input logic [8:0] w, input logic [15:0] fr, input int n);
    logic [15:0] f;
    int k;
    f = fr; k = n;
    if (k == 0) frame_model(d, w, f, k);
    @(negedge clk);
    chk("tx_ready before push", d, rdy[d], cnt[d] < DEPTH);
    v[d] = 1'b1; dat[d] = w;
    @(posedge clk); #1;
    v[d] = 1'b0; dat[d] = ~w;
    if (cnt[d] < DEPTH) begin
      cnt[d]++;
      sb_frame(d, f, k);
    end
    chk("fifo_count after push", d, fc[d], cnt[d]);
  endtask

  task automatic sb_check(input int d);
    ent_t e;
    logic has;
    has = (sb_size(d) != 0);
    e = has ? sb_pop(d) : 3'b001;
    chk("tx_serial", d, ser[d], e[0]);
    chk("tx_done", d, done[d], pend[d]);
    if (done[d] === 1'b1) begin
      gap[d] = tick_no - last_done[d];
      last_done[d] = tick_no;
    end
    pend[d] = has & e[2];
    chk("tx_busy", d, busy[d], has);
    if (has && e[1]) cnt[d]--;
    chk("fifo_count", d, fc[d], cnt[d]);
    chk("tx_ready", d, rdy[d], cnt[d] < DEPTH);
  endtask

  task automatic tick_edge();
    @(negedge clk); baud_tick = 1'b1;
    @(posedge clk); #1; baud_tick = 1'b0;
    tick_no++;
    for (int d = 0; d < ND; d++) sb_check(d);
  endtask

  task automatic tick();
    tick_edge();
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) chk("tx_done one clk", d, done[d], 1'b0);
    repeat (14) @(posedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 80;
    while ((sb_size(0) + sb_size(1) + sb_size(2) != 0 || pend != '0) && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain within budget", 0, budget > 0, 1'b1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{0, 9'h0A5, 16'b0101001011,  10};
    tbl[1] = '{1, 9'h055, 16'b01010101111, 11};
    tbl[2] = '{2, 9'h0FF, 16'b01111111101, 11};
    tbl[3] = '{2, 9'h07F, 16'b01111111011, 11};
    tbl[4] = '{0, 9'h000, 16'b0000000001,  10};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("reset tx_serial", d, ser[d], 1'b1);
      chk("reset tx_ready", d, rdy[d], 1'b1);
      chk("reset tx_busy", d, busy[d], 1'b0);
      chk("reset tx_done", d, done[d], 1'b0);
      chk("reset fifo_count", d, fc[d], 0);
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    // single frames, one per vector
    for (int i = 0; i < 5; i++) begin
      push(tbl[i].d, tbl[i].w, tbl[i].fr, tbl[i].n);
      drain();
    end

    // fill the 8N1 FIFO without ticks; the fifth push must be refused
    dc_snap = done_cnt[0];
    for (int i = 1; i <= 5; i++) push(0, 9'(i), 16'h0, 0);
    chk("full fifo_count", 0, fc[0], 4);
    drain();
    chk("done pulses for 4 frames", 0, done_cnt[0] - dc_snap, 4);

    // push held across the pop tick of a full FIFO
    for (int i = 0; i < 4; i++) push(0, 9'h10 + 9'(i), 16'h0, 0);
    v[0] = 1'b1; dat[0] = 9'h033;
    tick_edge();
    @(posedge clk); #1;
    v[0] = 1'b0;
    chk("held push accepted next clk", 0, fc[0], 4);
    begin
      logic [15:0] f;
      int k;
      frame_model(0, 9'h033, f, k);
      cnt[0]++;
      sb_frame(0, f, k);
    end
    repeat (14) @(posedge clk);
    drain();

    // reset in the middle of the data bits of a 0x00 frame
    push(0, 9'h000, 16'h0, 0);
    push(0, 9'h011, 16'h0, 0);
    repeat (3) tick();
    dc_snap = done_cnt[0];
    #3 rst = 1'b1;
    #1;
    chk("rst async tx_serial", 0, ser[0], 1'b1);
    chk("rst fifo_count", 0, fc[0], 0);
    chk("rst tx_busy", 0, busy[0], 1'b0);
    q0.delete(); q1.delete(); q2.delete();
    for (int d = 0; d < ND; d++) cnt[d] = 0;
    pend = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("no tx_done after abort", 0, done_cnt[0] - dc_snap, 0);
    chk("line idle after abort", 0, ser[0], 1'b1);
    push(0, tbl[0].w, tbl[0].fr, tbl[0].n);
    drain();
    chk("clean frame after reset", 0, done_cnt[0] - dc_snap, 1);

    // 8E1 back-to-back: tx_done spacing equals frame length
    push(2, 9'h0FF, 16'h0, 0);
    push(2, 9'h07F, 16'h0, 0);
    drain();
    chk("8E1 tx_done spacing", 2, gap[2], 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
